// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences word-aligned requests to instruction
// memory and hands instructions to decode through a registered IF/ID payload.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } state_t;

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  bootCnt_q, bootCnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        discard_q, discard_d;
    logic        ifValid_q, ifValid_d;
    logic [31:0] ifPc_q, ifPc_d;
    logic [31:0] ifInstr_q, ifInstr_d;
    logic        skidValid_q, skidValid_d;
    logic [31:0] skidPc_q, skidPc_d;
    logic [31:0] skidInstr_q, skidInstr_d;

    logic [31:0] redirectTarget;
    logic [31:0] pcPlus4;

    assign redirectTarget = redirect_pc_i & 32'hFFFF_FFFC;
    assign pcPlus4        = pc_q + 32'd4;

    assign imem_req_o  = (state_q == StFetch);
    assign imem_addr_o = addr_q;
    assign if_valid_o  = ifValid_q;
    assign if_pc_o     = ifPc_q;
    assign if_instr_o  = ifInstr_q;
    assign pc_o        = pc_q;

    always_comb begin
        state_d     = state_q;
        bootCnt_d   = bootCnt_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        ifValid_d   = ifValid_q;
        ifPc_d      = ifPc_q;
        ifInstr_d   = ifInstr_q;
        skidValid_d = skidValid_q;
        skidPc_d    = skidPc_q;
        skidInstr_d = skidInstr_q;

        unique case (state_q)
            StBoot: begin
                if (bootCnt_q == 4'd0) begin
                    state_d = StFetch;
                end else begin
                    bootCnt_d = bootCnt_q - 4'd1;
                end
            end

            StFetch: begin
                // A request is always in flight here, so a redirect without an
                // ack must remember to throw away the stale response.
                if (redirect_i) begin
                    pc_d        = redirectTarget;
                    ifValid_d   = 1'b0;
                    skidValid_d = 1'b0;
                    discard_d   = !imem_ack_i;
                end else begin
                    if (ifValid_q && !stall_i) begin
                        ifValid_d = 1'b0;
                    end
                    if (imem_ack_i) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else if (!ifValid_q || !stall_i) begin
                            ifValid_d = 1'b1;
                            ifPc_d    = addr_q;
                            ifInstr_d = imem_data_i;
                            pc_d      = pcPlus4;
                        end else begin
                            skidValid_d = 1'b1;
                            skidPc_d    = addr_q;
                            skidInstr_d = imem_data_i;
                            pc_d        = pcPlus4;
                            state_d     = StHold;
                        end
                    end
                end
            end

            StHold: begin
                if (redirect_i) begin
                    pc_d        = redirectTarget;
                    ifValid_d   = 1'b0;
                    skidValid_d = 1'b0;
                    state_d     = StFetch;
                end else if (!stall_i) begin
                    ifValid_d   = skidValid_q;
                    ifPc_d      = skidPc_q;
                    ifInstr_d   = skidInstr_q;
                    skidValid_d = 1'b0;
                    state_d     = StFetch;
                end
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // The address register only follows pc when no request is waiting for its ack.
    always_comb begin
        addr_d = pc_d;
        if (imem_req_o && !imem_ack_i) begin
            addr_d = addr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StBoot;
            bootCnt_q   <= BOOT_INIT;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            discard_q   <= 1'b0;
            ifValid_q   <= 1'b0;
            ifPc_q      <= 32'd0;
            ifInstr_q   <= 32'd0;
            skidValid_q <= 1'b0;
            skidPc_q    <= 32'd0;
            skidInstr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            bootCnt_q   <= bootCnt_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            discard_q   <= discard_d;
            ifValid_q   <= ifValid_d;
            ifPc_q      <= ifPc_d;
            ifInstr_q   <= ifInstr_d;
            skidValid_q <= skidValid_d;
            skidPc_q    <= skidPc_d;
            skidInstr_q <= skidInstr_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios followed by random traffic, all
// compared against a queue-based model of the fetch stream.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          BOOT_CYCLES = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic [31:0] pc_o;

    int compareCount  = 0;
    int mismatchCount = 0;

    fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .BOOT_CYCLES(BOOT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_instr_o   (if_instr_o),
        .pc_o         (pc_o)
    );

    always #5 clk = ~clk;

    // Model: instructions fetched but not yet consumed by decode sit in a queue
    // (at most two: the payload plus one buffered); fetching pauses when it is full.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mQueue[$];
    logic [31:0] mPc;
    logic [31:0] mOutAddr;
    bit          mOutstanding;
    bit          mDiscard;
    bit          mBooting;
    int          mBootLeft;

    function automatic void modelReset();
        mQueue.delete();
        mPc          = RESET_PC;
        mOutAddr     = RESET_PC;
        mOutstanding = 1'b0;
        mDiscard     = 1'b0;
        mBooting     = 1'b1;
        mBootLeft    = BOOT_CYCLES;
    endfunction

    function automatic bit modelReq();
        return !mBooting && (mQueue.size() < 2);
    endfunction

    function automatic logic [31:0] modelAddr();
        return mOutstanding ? mOutAddr : mPc;
    endfunction

    task automatic modelStep();
        bit          reqNow;
        logic [31:0] addrNow;
        if (rst) begin
            modelReset();
            return;
        end
        if (mBooting) begin
            if (mBootLeft == 0) mBooting = 1'b0;
            else mBootLeft--;
            return;
        end
        reqNow  = modelReq();
        addrNow = modelAddr();
        if (redirect_i) begin
            mPc = redirect_pc_i & ~32'd3;
            if (reqNow) mDiscard = !imem_ack_i;
            mQueue.delete();
        end else begin
            if (mQueue.size() > 0 && !stall_i) void'(mQueue.pop_front());
            if (reqNow && imem_ack_i) begin
                if (mDiscard) begin
                    mDiscard = 1'b0;
                end else begin
                    mQueue.push_back({addrNow, imem_data_i});
                    mPc = mPc + 32'd4;
                end
            end
        end
        mOutstanding = reqNow && !imem_ack_i;
        if (mOutstanding) mOutAddr = addrNow;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        compareCount++;
        assert (obs === exp) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check1("req", imem_req_o, modelReq());
        check32("addr", imem_addr_o, modelAddr());
        check32("pc", pc_o, mPc);
        check1("if_valid", if_valid_o, mQueue.size() > 0);
        if (mQueue.size() > 0) begin
            check32("if_pc", if_pc_o, mQueue[0].pc);
            check32("if_instr", if_instr_o, mQueue[0].instr);
        end
    endtask

    task automatic checkResetValues(input string tag);
        check1({tag, "_req"}, imem_req_o, 1'b0);
        check32({tag, "_addr"}, imem_addr_o, RESET_PC);
        check32({tag, "_pc"}, pc_o, RESET_PC);
        check1({tag, "_if_valid"}, if_valid_o, 1'b0);
        check32({tag, "_if_pc"}, if_pc_o, 32'd0);
        check32({tag, "_if_instr"}, if_instr_o, 32'd0);
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, then check.
    task automatic applyStimulus(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                                 input bit ack, input logic [31:0] data);
        rst           = r;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_ack_i    = ack;
        imem_data_i   = data;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        logic [31:0] d8;
        bit          st;
        bit          rd;
        bit          ack;
        bit          r;
        logic [31:0] rpc;

        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
        imem_ack_i = 1'b0; imem_data_i = 32'd0;
        modelReset();
        repeat (3) @(negedge clk);
        checkResetValues("por");

        // Boot: one counted idle cycle, first request on the second edge.
        rst = 1'b0;
        check1("boot_c0_req", imem_req_o, 1'b0);
        applyStimulus(0, 0, 0, 32'd0, 0, 32'd0);
        check1("boot_c1_req", imem_req_o, 1'b0);
        applyStimulus(0, 0, 0, 32'd0, 0, 32'd0);
        check1("boot_c2_req", imem_req_o, 1'b1);
        check32("boot_c2_addr", imem_addr_o, 32'h0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 32'd0, 1, $urandom);
            check1("seq_valid", if_valid_o, 1'b1);
            check32("seq_if_pc", if_pc_o, 32'(4 * i));
        end

        // Stall with a valid payload: the next instruction lands in the skid buffer.
        applyStimulus(0, 0, 1, 32'h4, 1, $urandom);
        check1("redir4_valid", if_valid_o, 1'b0);
        applyStimulus(0, 0, 0, 32'd0, 1, 32'hAAAA_0004);
        check32("p4_if_pc", if_pc_o, 32'h4);
        d8 = 32'hBBBB_0008;
        applyStimulus(0, 1, 0, 32'd0, 1, d8);
        check1("hold_req", imem_req_o, 1'b0);
        applyStimulus(0, 1, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 1, 0, 32'd0, 0, 32'd0);
        check1("hold3_req", imem_req_o, 1'b0);
        check32("hold3_if_pc", if_pc_o, 32'h4);
        applyStimulus(0, 0, 0, 32'd0, 0, 32'd0);
        check32("skid_if_pc", if_pc_o, 32'h8);
        check32("skid_if_instr", if_instr_o, d8);
        check32("after_skid_addr", imem_addr_o, 32'hC);

        // Redirect with the 0x10 request still pending.
        applyStimulus(0, 0, 0, 32'd0, 1, 32'hCCCC_000C);
        check32("pend_addr", imem_addr_o, 32'h10);
        applyStimulus(0, 0, 1, 32'h103, 0, 32'd0);
        check32("discard_addr_hold", imem_addr_o, 32'h10);
        check32("discard_pc", pc_o, 32'h100);
        applyStimulus(0, 0, 0, 32'd0, 0, 32'd0);
        check32("discard_addr_hold2", imem_addr_o, 32'h10);
        applyStimulus(0, 0, 0, 32'd0, 1, 32'hDEAD_0010);
        check1("dropped_valid", if_valid_o, 1'b0);
        check32("new_addr", imem_addr_o, 32'h100);
        applyStimulus(0, 0, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 0, 0, 32'd0, 1, 32'h1234_0100);
        check32("p100_if_pc", if_pc_o, 32'h100);

        // Redirect and ack together: dropped, no discard left behind.
        applyStimulus(0, 0, 1, 32'h200, 1, 32'hDEAD_0104);
        check32("same_edge_addr", imem_addr_o, 32'h200);
        applyStimulus(0, 0, 0, 32'd0, 1, 32'h5678_0200);
        check1("same_edge_valid", if_valid_o, 1'b1);
        check32("same_edge_if_pc", if_pc_o, 32'h200);

        // PC wrap at the top of the address space.
        applyStimulus(0, 0, 1, 32'hFFFF_FFFE, 1, $urandom);
        check32("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 32'd0, 1, 32'h0BAD_F00D);
        check32("wrap_pc", pc_o, 32'h0);

        // Asynchronous reset in the middle of HOLD, then a stale ack during boot.
        applyStimulus(0, 1, 0, 32'd0, 1, $urandom);
        check1("pre_rst_req", imem_req_o, 1'b0);
        imem_ack_i = 1'b0;
        #2 rst = 1'b1;
        #1 checkResetValues("async");
        imem_ack_i = 1'b1;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        applyStimulus(0, 0, 0, 32'd0, 1, 32'hDEAD_BEEF);
        check1("stale_valid", if_valid_o, 1'b0);
        check1("stale_req", imem_req_o, 1'b0);
        applyStimulus(0, 0, 0, 32'd0, 0, 32'd0);
        check32("rst_first_addr", imem_addr_o, RESET_PC);
        applyStimulus(0, 0, 0, 32'd0, 1, 32'h0000_1111);
        check32("rst_first_if_pc", if_pc_o, RESET_PC);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            st  = ($urandom_range(0, 9) < 4);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (modelReq()) ack = ($urandom_range(0, 9) < 6);
            else ack = mBooting && ($urandom_range(0, 4) == 0);
            applyStimulus(r, st, rd, rpc, ack, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter BOOT_CYCLES, default 1, SHALL be the number of idle cycles after reset release before the first fetch (range 0..15).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 stall_i  input  1  SHALL mean decode cannot accept the instruction currently presented.
REQ-006 redirect_i  input  1  SHALL mean a taken branch or jump; the fetch stream restarts at redirect_pc_i.
REQ-007 redirect_pc_i  input  32  SHALL be the redirect target address.
REQ-008 imem_req_o  output  1  SHALL be the instruction-memory request.
REQ-009 imem_addr_o  output  32  SHALL be the word-aligned request address.
REQ-010 imem_ack_i  input  1  SHALL mean imem_data_i is valid for the outstanding request.
REQ-011 imem_data_i  input  32  SHALL be the returned instruction.
REQ-012 if_valid_o / if_pc_o / if_instr_o  output  1/32/32  SHALL be the registered IF/ID payload.
REQ-013 pc_o  output  32  SHALL be the address of the next instruction to be requested.

Function
REQ-014 States SHALL be BOOT, FETCH and HOLD, plus a discard flag and a one-entry skid buffer (pc, instr, valid).
REQ-015 BOOT SHALL count BOOT_CYCLES cycles with imem_req_o=0, then enter FETCH; BOOT_CYCLES=0 SHALL enter FETCH on the first edge after reset release; redirect_i SHALL be ignored in BOOT.
REQ-016 FETCH: imem_req_o SHALL be 1; imem_addr_o SHALL come from a register loaded at request launch, held stable until imem_ack_i, and never withdrawn before ack.
REQ-017 imem_ack_i is legal in the same cycle a request launches (zero-wait memory); back-to-back requests SHALL sustain one instruction per cycle.
REQ-018 Decode consumes the payload on any edge with if_valid_o=1 and stall_i=0.
REQ-019 Ack, no discard, no redirect, payload empty or consumed this edge: if_* SHALL load {1, fetch address, imem_data_i}; pc SHALL advance by 4.
REQ-020 Ack while payload is valid and stall_i=1: the instruction SHALL go to the skid buffer; pc SHALL advance by 4; state SHALL become HOLD with imem_req_o=0.
REQ-021 HOLD: when stall_i=0, if_* SHALL load from the skid buffer, the skid SHALL clear, and state SHALL return to FETCH.
REQ-022 Redirect SHALL have highest priority over ack, stall and HOLD. It SHALL set pc to {redirect_pc_i[31:2], 2'b00}, clear if_valid_o and the skid, and enter FETCH.
REQ-023 Redirect with a request outstanding and no ack this edge: the discard flag SHALL set, and the request SHALL stay asserted at its old address until ack.
REQ-024 An ack with discard set SHALL drop the data, clear discard and leave pc unchanged; the next request SHALL use the new pc.
REQ-025 An ack on the same edge as a redirect SHALL be dropped, and discard SHALL NOT be set.
REQ-026 A second redirect while discard is set SHALL update pc only.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 The address SHALL never change while imem_req_o=1 and ack is pending.

Reset
REQ-029 When rst=1 asynchronously, and while it remains asserted: state=BOOT; pc_o=RESET_PC; imem_req_o=0; imem_addr_o=RESET_PC; if_valid_o=0; if_pc_o=0; if_instr_o=0; skid and discard cleared; boot counter=BOOT_CYCLES.
REQ-030 Reset asserted mid-request SHALL abandon the request; after reset release the first ack accepted SHALL belong to the new RESET_PC request.

Verification
REQ-031 Reset, BOOT_CYCLES=1, ack every cycle, no stall -> first req at cycle 2 (addr 0); if_pc_o sequence 0,4,8 on consecutive cycles.
REQ-032 stall_i=1 for 3 cycles with payload 0x4 valid and ack on 0x8 -> 0x8 held in skid; req low; on stall release if_pc_o=0x8 next cycle, then fetch 0xC.
REQ-033 Request to 0x10 pending; redirect to 0x103 with ack 2 cycles later -> addr stays 0x10 until ack; data dropped; next req addr=0x100; if_valid_o=0 until 0x100 returns.
REQ-034 Redirect and ack on the same edge -> data dropped; discard not set; next req addr=redirect target.
REQ-035 pc=0xFFFF_FFFC, ack -> pc_o=0x0000_0000.
REQ-036 rst pulsed mid-HOLD -> all outputs at reset values immediately; a stale ack after reset release is ignored.
